// File: rtl/jtcps1_pkg.sv
// Shared definitions for the CPS1 per-line render scheduler.
package jtcps1_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    GO   = 2'd2,
    WAIT = 2'd3
  } sched_state_e;

  localparam int unsigned JOB_SCR1  = 0;
  localparam int unsigned JOB_SCR2  = 1;
  localparam int unsigned JOB_SCR3  = 2;
  localparam int unsigned JOB_OBJ   = 3;
  localparam int unsigned NJOBS_DEF = 4;

endpackage

// File: rtl/jtcps1_line_sched_if.sv
// Job launch/completion bundle between the line scheduler and the render jobs.
interface jtcps1_line_sched_if
  import jtcps1_pkg::*;
#(
  parameter int unsigned NJOBS = NJOBS_DEF
);
  logic [NJOBS-1:0] job_go;
  logic             job_abort;
  logic [8:0]       job_line;
  logic [NJOBS-1:0] job_done;

  modport master (
    output job_go,
    output job_abort,
    output job_line,
    input  job_done
  );

  modport slave (
    input  job_go,
    input  job_abort,
    input  job_line,
    output job_done
  );
endinterface

// File: rtl/jtcps1_edge.sv
// Rising-edge detector; history resets high so a level held through reset is ignored.
module jtcps1_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic din_q;

  always_ff @(posedge clk) begin
    if (rst) din_q <= 1'b1;
    else     din_q <= din;
  end

  assign rise = din & ~din_q;
endmodule

// File: rtl/jtcps1_line_sched.sv
// Per-scanline render scheduler: launches enabled jobs in order on each line start,
// flips the line-buffer select and counts chains overrun by the next line.
module jtcps1_line_sched
  import jtcps1_pkg::*;
#(
  parameter int unsigned NJOBS = NJOBS_DEF,
  parameter int unsigned OVRW  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                preVB,
  input  logic [8:0]          vrender,
  input  logic [NJOBS-1:0]    job_en,
  jtcps1_line_sched_if.master jobs,
  output logic                buf_sel,
  output logic                busy,
  input  logic                ovr_clr,
  output logic [OVRW-1:0]     ovr_cnt
);
  localparam int unsigned IW = $clog2(NJOBS + 1);
  typedef logic [IW-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(NJOBS);

  sched_state_e     state_q, state_d;
  idx_t             idx_q, idx_d;
  logic [NJOBS-1:0] en_q, en_d;
  logic [8:0]       line_q, line_d;
  logic             buf_q, buf_d;
  logic             abort_q, abort_d;
  logic [OVRW-1:0]  ovr_q, ovr_d;

  logic             st_edge;
  logic             cur_en, cur_done, later_en;
  logic             done_last, overrun;
  logic [NJOBS-1:0] go;

  jtcps1_edge u_st_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (start),
    .rise (st_edge)
  );

  // Decode the current job slot and whether any enabled job remains after it.
  always_comb begin
    cur_en   = 1'b0;
    cur_done = 1'b0;
    later_en = 1'b0;
    go       = '0;
    for (int unsigned j = 0; j < NJOBS; j++) begin
      if (idx_q == idx_t'(j)) begin
        cur_en   = en_q[j];
        cur_done = jobs.job_done[j];
      end
      if (idx_t'(j) > idx_q) later_en = later_en | en_q[j];
      go[j] = (state_q == GO) && (idx_q == idx_t'(j));
    end
  end

  assign busy      = (state_q != IDLE);
  // A new line landing on the final done is a clean completion, not an overrun.
  assign done_last = (state_q == WAIT) && cur_done && !later_en;
  assign overrun   = st_edge && busy && !done_last;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    line_d  = line_q;
    buf_d   = buf_q;
    abort_d = 1'b0;
    ovr_d   = ovr_q;

    case (state_q)
      IDLE: ;
      SEEK: begin
        if (idx_q == LAST_IDX) state_d = IDLE;
        else if (!cur_en)      idx_d   = idx_q + idx_t'(1);
        else                   state_d = GO;
      end
      GO:   state_d = WAIT;
      WAIT: begin
        if (cur_done) begin
          idx_d   = idx_q + idx_t'(1);
          state_d = SEEK;
        end
      end
      default: state_d = IDLE;
    endcase

    if (st_edge) begin
      if (overrun) begin
        abort_d = (state_q != SEEK);
        if (ovr_q != '1) ovr_d = ovr_q + OVRW'(1);
      end
      if (preVB) begin
        state_d = IDLE;
      end else begin
        line_d  = vrender;
        en_d    = job_en;
        buf_d   = ~buf_q;
        idx_d   = '0;
        state_d = SEEK;
      end
    end

    if (ovr_clr) ovr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      en_q    <= '0;
      line_q  <= '0;
      buf_q   <= 1'b0;
      abort_q <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      line_q  <= line_d;
      buf_q   <= buf_d;
      abort_q <= abort_d;
      ovr_q   <= ovr_d;
    end
  end

  assign jobs.job_go    = go;
  assign jobs.job_abort = abort_q;
  assign jobs.job_line  = line_q;
  assign buf_sel        = buf_q;
  assign ovr_cnt        = ovr_q;
endmodule

// File: tb/tb_jtcps1_line_sched.sv
// Randomized scoreboard bench for the line scheduler: expected go/abort events are
// queued from a line-level model and popped by a monitor whenever the DUT strobes.
module tb_jtcps1_line_sched;
  import jtcps1_pkg::*;

  localparam int unsigned NJ = 4;
  localparam int unsigned OW = 8;
  localparam int OVR_MAX = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          preVB = 1'b0;
  logic          ovr_clr = 1'b0;
  logic [8:0]    vrender = '0;
  logic [NJ-1:0] job_en = '0;
  logic          buf_sel, busy;
  logic [OW-1:0] ovr_cnt;

  jtcps1_line_sched_if #(.NJOBS(NJ)) jobs ();

  jtcps1_line_sched #(.NJOBS(NJ), .OVRW(OW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .preVB   (preVB),
    .vrender (vrender),
    .job_en  (job_en),
    .jobs    (jobs),
    .buf_sel (buf_sel),
    .busy    (busy),
    .ovr_clr (ovr_clr),
    .ovr_cnt (ovr_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_abort;
    logic [NJ-1:0] mask;
    logic [8:0]    line;
    int            at;
  } ev_t;

  ev_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Line-level model state
  bit            model_busy = 1'b0;
  bit            buf_m = 1'b0;
  int            ovr_m = 0;
  logic [8:0]    line_m = '0;
  logic [NJ-1:0] carry = '0;
  int            start_left = 0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input bit ab, input int job, input logic [8:0] ln, input int at);
    ev_t e;
    e.is_abort = ab;
    e.mask     = '0;
    if (!ab) e.mask[job] = 1'b1;
    e.line     = ln;
    e.at       = at;
    exp_q.push_back(e);
  endtask

  task automatic take(input bit ab, input logic [NJ-1:0] m);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got abort=%0d go=%b line=%0d at cycle %0d, required none",
               ab, m, jobs.job_line, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.is_abort != ab || e.mask != m || e.at != cyc || (!ab && e.line != jobs.job_line)) begin
        miscompares++;
        $display("FAIL event: got abort=%0d go=%b line=%0d cycle=%0d, required abort=%0d go=%b line=%0d cycle=%0d",
                 ab, m, jobs.job_line, cyc, e.is_abort, e.mask, e.line, e.at);
      end
    end
  endtask

  function automatic int first_en(input logic [NJ-1:0] en);
    for (int j = 0; j < NJ; j++) if (en[j]) return j;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    jobs.job_done = '0;
    ovr_clr = 1'b0;
    if (start_left > 0) start_left--;
    start = (start_left > 0);
  endtask

  task automatic do_start(input logic [8:0] vr, input logic [NJ-1:0] en, input bit pvb,
                          input bit clr);
    int f;
    while (start_left > 0) tick();
    tick();
    start = 1'b1;
    start_left = 4;
    vrender = vr;
    job_en = en;
    preVB = pvb;
    ovr_clr = clr;
    jobs.job_done = carry;
    if (model_busy && carry == '0) begin
      push_ev(1'b1, 0, '0, cyc + 1);
      ovr_m = (ovr_m < OVR_MAX) ? ovr_m + 1 : OVR_MAX;
    end
    if (clr) ovr_m = 0;
    carry = '0;
    if (pvb) begin
      model_busy = 1'b0;
    end else begin
      buf_m = !buf_m;
      line_m = vr;
      model_busy = (en != '0);
      f = first_en(en);
      if (f >= 0) push_ev(1'b0, f, vr, cyc + 2 + f);
    end
  endtask

  // mode 0: all jobs complete; 1: job at position hang_k never completes;
  // 2: last done lands in the same cycle as the next line start.
  task automatic run_line(input logic [8:0] vr, input logic [NJ-1:0] en, input bit pvb,
                          input int mode, input int hang_k, input int dly, input bit clr);
    int idx[$];
    int to;
    int d;
    do_start(vr, en, pvb, clr);
    if (pvb) begin
      tick();
      check("busy_after_prevb", int'(busy), 0);
    end else begin
      for (int j = 0; j < NJ; j++) if (en[j]) idx.push_back(j);
    end
    for (int p = 0; p < idx.size(); p++) begin
      to = 0;
      while (!jobs.job_go[idx[p]] && to < 40) begin
        tick();
        to++;
      end
      if (to >= 40) begin
        vectors++;
        miscompares++;
        $display("FAIL go_timeout: got no job_go for job %0d, required a strobe", idx[p]);
        return;
      end
      if (mode == 1 && p == hang_k) begin
        repeat (2) tick();
        while (start_left > 0) tick();
        check("ovr_cnt_hang", int'(ovr_cnt), ovr_m);
        check("job_line_hang", int'(jobs.job_line), int'(line_m));
        return;
      end
      d = (dly > 0) ? dly : int'($urandom_range(1, 5));
      repeat (d) tick();
      if (mode == 2 && p == idx.size() - 1) begin
        while (start_left > 0) tick();
        carry = '0;
        carry[idx[p]] = 1'b1;
        return;
      end
      jobs.job_done[idx[p]] = 1'b1;
      if (p + 1 < idx.size())
        push_ev(1'b0, idx[p+1], vr, cyc + 2 + (idx[p+1] - idx[p] - 1));
    end
    repeat (10) tick();
    while (start_left > 0) tick();
    model_busy = 1'b0;
    check("busy_idle", int'(busy), 0);
    check("buf_sel", int'(buf_sel), int'(buf_m));
    check("ovr_cnt", int'(ovr_cnt), ovr_m);
    check("job_line", int'(jobs.job_line), int'(line_m));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NJ-1:0] en;
    bit pvb;
    int mode, n, hk;

    jobs.job_done = '0;
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (jobs.job_abort) take(1'b1, '0);
          if (jobs.job_go != '0) take(1'b0, jobs.job_go);
        end
      end
    join_none

    // Reset with start held high: releasing reset must not look like a line start.
    start = 1'b1;
    start_left = 12;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("rst_buf_sel", int'(buf_sel), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovr_cnt", int'(ovr_cnt), 0);
    check("rst_job_line", int'(jobs.job_line), 0);
    while (start_left > 0) tick();

    run_line(9'h020, 4'b1111, 1'b0, 0, 0, 5, 1'b0);
    run_line(9'h031, 4'b1010, 1'b0, 0, 0, 0, 1'b0);
    run_line(9'h045, 4'b0000, 1'b0, 0, 0, 0, 1'b0);

    // Hung job 2 overrun by every following line, until the counter saturates.
    for (int i = 0; i < 301; i++) run_line(9'(i), 4'b1111, 1'b0, 1, 2, 0, 1'b0);
    check("ovr_saturated", int'(ovr_cnt), OVR_MAX);
    tick();
    ovr_clr = 1'b1;
    ovr_m = 0;
    tick();
    check("ovr_cleared", int'(ovr_cnt), 0);

    // Last done coinciding with the next start is a completion.
    run_line(9'h0a0, 4'b1111, 1'b0, 2, 0, 0, 1'b0);
    run_line(9'h0a1, 4'b0110, 1'b0, 0, 0, 0, 1'b0);

    for (int i = 0; i < 10; i++) run_line(9'($urandom), 4'($urandom), 1'b1, 0, 0, 0, 1'b0);

    // Busy chain hit by a blanked line start.
    run_line(9'h0b0, 4'(1 << JOB_SCR1) | 4'(1 << JOB_OBJ), 1'b0, 1, 0, 0, 1'b0);
    run_line(9'h0b1, 4'b1111, 1'b1, 0, 0, 0, 1'b0);
    check("ovr_after_prevb", int'(ovr_cnt), ovr_m);

    // Overrun together with a clear: the clear wins.
    run_line(9'h0c0, 4'b1111, 1'b0, 1, 1, 0, 1'b0);
    run_line(9'h0c1, 4'(1 << JOB_SCR2) | 4'(1 << JOB_SCR3), 1'b0, 0, 0, 0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      en = 4'($urandom);
      pvb = ($urandom_range(0, 4) == 0);
      n = $countones(en);
      mode = int'($urandom_range(0, 2));
      if (pvb || n == 0) mode = 0;
      hk = (mode == 1) ? int'($urandom_range(0, n - 1)) : 0;
      run_line(9'($urandom), en, pvb, mode, hk, 0, ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of a chain.
    run_line(9'h0d0, 4'b1111, 1'b0, 1, 1, 0, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_go", int'(jobs.job_go), 0);
    check("midrst_abort", int'(jobs.job_abort), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_buf_sel", int'(buf_sel), 0);
    check("midrst_ovr_cnt", int'(ovr_cnt), 0);
    check("midrst_job_line", int'(jobs.job_line), 0);
    rst = 1'b0;
    model_busy = 1'b0;
    buf_m = 1'b0;
    ovr_m = 0;
    line_m = '0;
    carry = '0;
    run_line(9'h0e0, 4'b0101, 1'b0, 0, 0, 0, 1'b0);

    repeat (5) tick();
    check("events_outstanding", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/jtcps1_line_sched.md
Name: jtcps1_line_sched

Overview:
- Per-scanline render scheduler driven by the CPS1 video timing generator.
- On every line-start pulse it latches the line number to render and runs the enabled render jobs strictly in order, one at a time, using a go/done handshake. The jobs are scroll1, scroll2, scroll3 and objects.
- Flips the ping-pong line-buffer select once per active line.
- Counts overruns: a new line started before the job chain finished.

Parameters:
- NJOBS, 4, number of render jobs; job 0 has highest priority and is issued first.
- OVRW, 8, width of the saturating overrun counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  line-start flag from the timing generator. It is high for a whole cen8 period, so it spans several clk cycles.
- preVB  input  1  vertical-blank-ahead flag; high means the line is not rendered.
- vrender  input  9  line number to be rendered; sampled on the start edge.
- job_en  input  NJOBS  per-job enable; sampled on the start edge.
- job_done  input  NJOBS  per-job completion pulse; one cycle, level also accepted.
- job_go  output  NJOBS  one-cycle launch strobe per job.
- job_abort  output  1  one-cycle pulse that cancels the job in flight.
- job_line  output  9  latched line number, held stable for the whole chain.
- buf_sel  output  1  ping-pong line-buffer select.
- busy  output  1  high while the chain is in progress.
- ovr_clr  input  1  clears the overrun counter.
- ovr_cnt  output  OVRW  saturating overrun count.

Behaviour:
- Line-start edge: st_edge = start & ~start_q, where start_q is start delayed one clk. Only st_edge is acted on.
- Reset values:
  - job_go=0, job_abort=0, job_line=0, buf_sel=0, busy=0, ovr_cnt=0.
  - Internal state IDLE, job index 0, start_q=1, so a start held high through reset does not trigger.
- States: IDLE, SEEK, GO, WAIT.
- IDLE, on st_edge:
  - If preVB=1: stay in IDLE. job_line and buf_sel are unchanged and no job is issued.
  - If preVB=0: job_line<=vrender, en_q<=job_en, buf_sel<=~buf_sel, idx<=0, busy<=1, go to SEEK.
- SEEK (one cycle per examined index):
  - idx==NJOBS: busy<=0, go to IDLE.
  - en_q[idx]=0: idx<=idx+1, stay in SEEK.
  - Otherwise go to GO.
- GO:
  - job_go[idx]=1 for exactly one cycle, then go to WAIT.
  - Latency from st_edge to the first job_go is 2 clk when job 0 is enabled, plus 1 clk per skipped job.
- WAIT:
  - On job_done[idx]: idx<=idx+1, go to SEEK.
  - job_done bits for other jobs are ignored.
  - No timeout; the chain ends only through done or a new line.
- st_edge while busy (overrun):
  - job_abort=1 for one cycle, unless the state is SEEK.
  - ovr_cnt increments, saturating at all ones.
  - The new line is then handled exactly as in IDLE: preVB=0 restarts the chain at index 0; preVB=1 drops to IDLE with busy=0.
- Same-cycle conflicts:
  - st_edge together with job_done of the last enabled job counts as completion: no abort and no overrun increment, and the new line is processed normally.
  - st_edge together with ovr_clr: the clear wins and ovr_cnt becomes 0.
- All-zero job_en on an active line: buf_sel still toggles; the chain passes SEEK for NJOBS+1 cycles, then busy drops with no job_go.
- Reset mid-chain: all outputs return to their reset values on the next clk. No abort is issued; downstream jobs share the same reset.
- job_line and en_q change only on an accepted st_edge.

Decomposition:
- Shared package jtcps1_pkg holds:
  - state encoding constants: IDLE, SEEK, GO, WAIT;
  - job index constants: JOB_SCR1=0, JOB_SCR2=1, JOB_SCR3=2, JOB_OBJ=3.
- One natural sub-module, jtcps1_edge: rising-edge detector with a synchronous reset value of 1. It is reused for st_edge.

Test Plan:
- Reset with start=1 held, then release → no job_go issued and buf_sel=0 until the next rising start.
- preVB=0, vrender=0x20, job_en=4'b1111, each job_done 5 clk after its go → job_go strobes 1,2,4,8 in order; job_line=0x20 throughout; busy falls after job 3 done; buf_sel=1; ovr_cnt=0.
- job_en=4'b1010 → first job_go=4'b0010 arrives 3 clk after st_edge; then job_go=4'b1000; job 0 and job 2 are never strobed.
- job 2 never completes and the next st_edge arrives → job_abort pulses once, ovr_cnt=1, and job_go[0] restarts with the new vrender. Repeat 300 times → ovr_cnt saturates at 255; a single ovr_clr pulse returns it to 0.
- st_edge in the same cycle as job_done[3] → ovr_cnt unchanged and no job_abort.
- preVB=1 for 10 line starts → no job_go, buf_sel constant, busy=0. With the chain busy, a st_edge arriving with preVB=1 → job_abort pulses, ovr_cnt increments by 1, busy falls the next cycle.
